// File: rtl/n2_pwl_pipe.sv
// Multi-lane piecewise-linear evaluator: Y = sat(((a[seg]*X) >>> FRAC) + b[seg]).
// Three-stage pipeline with one shared coefficient table that is reloaded only while drained.
module n2_pwl_pipe #(
  parameter int N        = 16,
  parameter int Tn       = 16,
  parameter int FRAC     = 8,
  parameter int SEG_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [Tn*N-1:0]     i_X,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [Tn*N-1:0]     o_Y,
  input  logic                i_load_req,
  output logic                o_load_ack,
  input  logic                i_coef_we,
  input  logic [SEG_BITS-1:0] i_coef_addr,
  input  logic [2*N-1:0]      i_coef_data
);

  localparam int                  SEGS     = 2 ** SEG_BITS;
  localparam logic [SEG_BITS-1:0] SEG_FLIP = {1'b1, {(SEG_BITS-1){1'b0}}};
  localparam logic [N-1:0]        Y_MAX    = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]        Y_MIN    = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

  state_t r_state;
  logic   r_load_ack;

  logic [2*N-1:0] r_tab [SEGS];

  logic r_s1_v, r_s2_v, r_s3_v;
  logic signed [N-1:0]   r1_x [Tn];
  logic signed [N-1:0]   r1_a [Tn];
  logic signed [N-1:0]   r1_b [Tn];
  logic signed [2*N-1:0] r2_p [Tn];
  logic signed [N-1:0]   r2_b [Tn];
  logic [Tn*N-1:0]       r_y;

  logic                w_adv;
  logic                w_acc;
  logic [SEG_BITS-1:0] w_seg [Tn];

  function automatic logic [N-1:0] f_sat_add(input logic signed [2*N-1:0] p,
                                             input logic signed [N-1:0]   b);
    logic signed [2*N:0] s;
    s = (2*N+1)'(p >>> FRAC) + (2*N+1)'(b);
    if (s[2*N:N-1] == {(N+2){s[2*N]}}) return s[N-1:0];
    return s[2*N] ? Y_MIN : Y_MAX;
  endfunction

  // The whole pipeline stalls as one unit whenever the output register is held.
  assign w_adv      = !(r_s3_v && !i_ready);
  assign o_ready    = (r_state == RUN) && w_adv;
  assign w_acc      = i_valid && o_ready;
  assign o_valid    = r_s3_v;
  assign o_Y        = r_y;
  assign o_load_ack = r_load_ack;

  // NOTE: combinational blocks use blocking '=' and sequential blocks use '<=' so
  // every flop samples values from before the clock edge.
  always_comb begin
    for (int k = 0; k < Tn; k++) begin
      w_seg[k] = i_X[k*N+N-1 -: SEG_BITS] ^ SEG_FLIP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_load_ack <= 1'b0;
    end else begin
      case (r_state)
        RUN:   if (i_load_req) r_state <= DRAIN;
        DRAIN: if (!r_s1_v && !r_s2_v && !r_s3_v) begin
                 r_state    <= LOAD;
                 r_load_ack <= 1'b1;
               end
        LOAD:  if (!i_load_req) begin
                 r_state    <= RUN;
                 r_load_ack <= 1'b0;
               end
        default: begin
          r_state    <= RUN;
          r_load_ack <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the coefficient table is deliberately not reset so it survives rst and
  // can map onto plain RAM; only the LOAD state may write it.
  always_ff @(posedge clk) begin
    if (!rst && r_state == LOAD && i_coef_we) r_tab[i_coef_addr] <= i_coef_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
      r_s3_v <= 1'b0;
      r_y    <= '0;
    end else if (w_adv) begin
      r_s1_v <= w_acc;
      r_s2_v <= r_s1_v;
      r_s3_v <= r_s2_v;
      if (r_s2_v) begin
        for (int k = 0; k < Tn; k++) r_y[k*N +: N] <= f_sat_add(r2_p[k], r2_b[k]);
      end
    end
  end

  // NOTE: datapath registers carry no reset; the stage-valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      for (int k = 0; k < Tn; k++) begin
        if (w_acc) begin
          r1_x[k] <= i_X[k*N +: N];
          r1_a[k] <= r_tab[w_seg[k]][2*N-1:N];
          r1_b[k] <= r_tab[w_seg[k]][N-1:0];
        end
        if (r_s1_v) begin
          r2_p[k] <= (2*N)'(r1_a[k]) * (2*N)'(r1_x[k]);
          r2_b[k] <= r1_b[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_n2_pwl_pipe.sv
// Randomized bench for n2_pwl_pipe: a scoreboard fed by an arithmetic model of the
// PWL function, plus directed latency, saturation, load-drain and reset scenarios.
module tb_n2_pwl_pipe;

  localparam int N    = 16;
  localparam int TN   = 16;
  localparam int FRAC = 8;
  localparam int SB   = 4;
  localparam int W    = TN * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  i_X;
  logic          o_valid;
  logic          i_ready;
  logic [W-1:0]  o_Y;
  logic          i_load_req;
  logic          o_load_ack;
  logic          i_coef_we;
  logic [SB-1:0] i_coef_addr;
  logic [2*N-1:0] i_coef_data;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int ready_mode = 0;

  int            ta  [16];
  int            tbv [16];
  logic [15:0]   pa  [16];
  logic [15:0]   pb  [16];
  logic [W-1:0]  exp_q [$];
  logic          stalled = 1'b0;
  logic [W-1:0]  held_y;

  n2_pwl_pipe #(.N(N), .Tn(TN), .FRAC(FRAC), .SEG_BITS(SB)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .o_ready(o_ready), .i_X(i_X),
    .o_valid(o_valid), .i_ready(i_ready), .o_Y(o_Y),
    .i_load_req(i_load_req), .o_load_ack(o_load_ack),
    .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       i_ready = 1'b1;
        1:       i_ready = 1'($urandom_range(0, 1));
        default: i_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: per lane, pick the segment from the top bits with the sign bit
  // inverted, then floor((a*x)/2^FRAC) + b clamped to the signed N-bit range.
  function automatic logic [W-1:0] model(input logic [W-1:0] x);
    logic [W-1:0] y;
    int     xs, seg;
    longint s;
    y = '0;
    for (int k = 0; k < TN; k++) begin
      xs  = int'($signed(x[k*N +: N]));
      seg = int'(x[k*N+N-SB +: SB]) ^ 8;
      s   = (longint'(ta[seg]) * longint'(xs)) >>> FRAC;
      s   = s + longint'(tbv[seg]);
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      y[k*N +: N] = s[N-1:0];
    end
    return y;
  endfunction

  function automatic logic [W-1:0] same_vec(input logic [15:0] x);
    return {TN{x}};
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int k = 0; k < TN; k++) v[k*N +: N] = N'($urandom);
    return v;
  endfunction

  // Scoreboard: record accepted inputs, compare transferred outputs in order,
  // and require o_Y to hold steady across stalled cycles.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled && o_valid) chk("hold_stable", o_Y, held_y);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", W'(o_valid), W'(0));
        else                   chk("out_vector", o_Y, exp_q.pop_front());
      end
      stalled = o_valid && !i_ready;
      held_y  = o_Y;
      if (i_valid && o_ready) exp_q.push_back(model(i_X));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input int m);
    ready_mode = m;
    repeat (2) tick();
  endtask

  task automatic send(input logic [W-1:0] x);
    int n;
    i_valid = 1'b1;
    i_X     = x;
    n       = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_ready && n < 200);
    if (!o_ready) chk("send_timeout", W'(o_ready), W'(1));
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || o_valid) && n < 500);
    if (exp_q.size() != 0 || o_valid) chk("drain_timeout", W'(exp_q.size()), W'(0));
    tick();
  endtask

  task automatic send_latency(input logic [15:0] x, input logic [15:0] y, input string tag);
    send(same_vec(x));
    @(negedge clk); chk({tag, "_lat1"}, W'(o_valid), W'(0));
    @(negedge clk); chk({tag, "_lat2"}, W'(o_valid), W'(0));
    @(negedge clk); chk({tag, "_lat3"}, W'(o_valid), W'(1));
    chk(tag, o_Y, same_vec(y));
    tick();
  endtask

  task automatic load_segs(input int first, input int last);
    int n;
    i_load_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!o_load_ack && n > 1) chk("drain_ready", W'(o_ready), W'(0));
    end while (!o_load_ack && n < 500);
    chk("load_ack", W'(o_load_ack), W'(1));
    chk("ack_after_drain", W'(exp_q.size()) | W'(o_valid), W'(0));
    tick();
    for (int s = first; s <= last; s++) begin
      i_coef_we   = 1'b1;
      i_coef_addr = SB'(s);
      i_coef_data = {pa[s], pb[s]};
      if (s == last) i_load_req = 1'b0;
      tick();
      ta[s]  = int'($signed(pa[s]));
      tbv[s] = int'($signed(pb[s]));
    end
    i_coef_we = 1'b0;
    @(negedge clk);
    chk("ack_drop", W'(o_load_ack), W'(0));
    chk("ready_after_load", W'(o_ready), W'(1));
    tick();
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_X = '0; i_load_req = 1'b0;
    i_coef_we = 1'b0; i_coef_addr = '0; i_coef_data = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", W'(o_valid), W'(0));
    chk("rst_y", o_Y, W'(0));
    chk("rst_ack", W'(o_load_ack), W'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", W'(o_ready), W'(1));
    tick();

    // Full table load, with the segments used by the directed checks fixed.
    for (int s = 0; s < 16; s++) begin
      pa[s] = 16'($urandom);
      pb[s] = 16'($urandom);
    end
    pa[8] = 16'h0040; pb[8] = 16'h0080;
    pa[7] = 16'h0000; pb[7] = 16'h8000;
    load_segs(0, 15);

    send_latency(16'h0100, 16'h00C0, "basic_pwl");

    pa[8] = 16'h7FFF; pb[8] = 16'h7FFF;
    load_segs(8, 8);
    send_latency(16'h0100, 16'h7FFF, "sat_pos");
    send_latency(16'hFF00, 16'h8000, "sat_neg");

    // Random backpressure stream.
    set_ready(1);
    repeat (40) send(rand_vec());
    wait_empty();

    // Back-to-back throughput with the sink always ready.
    set_ready(0);
    begin
      int c0;
      c0 = cyc;
      repeat (16) send(rand_vec());
      chk("throughput_cycles", W'(cyc - c0), W'(16));
    end
    wait_empty();

    // Load request with three vectors in flight.
    send(rand_vec()); send(rand_vec()); send(rand_vec());
    for (int s = 0; s < 16; s++) begin
      pa[s] = 16'($urandom);
      pb[s] = 16'($urandom);
    end
    load_segs(0, 15);
    set_ready(1);
    repeat (12) send(rand_vec());
    wait_empty();

    // Coefficient writes while running must be ignored.
    set_ready(0);
    for (int s = 0; s < 16; s++) begin
      i_coef_we   = 1'b1;
      i_coef_addr = SB'(s);
      i_coef_data = 32'($urandom);
      tick();
    end
    i_coef_we = 1'b0;
    repeat (12) send(rand_vec());
    wait_empty();

    // Reset while draining with two vectors in flight.
    set_ready(2);
    send(rand_vec()); send(rand_vec());
    i_load_req = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_drain_valid", W'(o_valid), W'(0));
    chk("rst_drain_ack", W'(o_load_ack), W'(0));
    tick();
    rst = 1'b0;
    i_load_req = 1'b0;
    ready_mode = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale", W'(o_valid), W'(0));
    end
    tick();
    set_ready(1);
    repeat (12) send(rand_vec());
    wait_empty();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/n2_pwl_pipe.md
N2_PWL_PIPE -- requirements
Module: n2_pwl_pipe

Interface
REQ-001 SHALL have parameter N, default 16: data word width, signed two's-complement fixed point.
REQ-002 SHALL have parameter Tn, default 16: number of parallel lanes sharing one coefficient table.
REQ-003 SHALL have parameter FRAC, default 8: fraction bits of X, a, b and Y.
REQ-004 SHALL have parameter SEG_BITS, default 4: the table holds 2^SEG_BITS segments.
REQ-005 SHALL have port clk, input, 1: single clock, all state on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port i_valid, input, 1: input vector valid.
REQ-008 SHALL have port o_ready, output, 1: block accepts the input vector.
REQ-009 SHALL have port i_X, input, Tn*N: input lanes; lane k at bits [(k+1)*N-1 : k*N].
REQ-010 SHALL have port o_valid, output, 1: output vector valid.
REQ-011 SHALL have port i_ready, input, 1: downstream accepts the output vector.
REQ-012 SHALL have port o_Y, output, Tn*N: output lanes, packed as i_X.
REQ-013 SHALL have port i_load_req, input, 1: request for coefficient-load mode.
REQ-014 SHALL have port o_load_ack, output, 1: block is in LOAD and table writes are accepted.
REQ-015 SHALL have port i_coef_we, input, 1: table write strobe.
REQ-016 SHALL have port i_coef_addr, input, SEG_BITS: segment written.
REQ-017 SHALL have port i_coef_data, input, 2*N: {a[2N-1:N], b[N-1:0]}.

Function
REQ-018 SHALL transfer an input when i_valid && o_ready, and an output when o_valid && i_ready.
REQ-019 SHALL compute seg = {~X[N-1], X[N-2 : N-SEG_BITS]} per lane, so segment order is monotone in X.
REQ-020 SHALL compute per lane Y = sat_N( ((a[seg] * X) >>> FRAC) + b[seg] ), with a full 2N-bit signed product and an arithmetic shift (floor).
REQ-021 SHALL saturate to the range 0x7FFF..0x8000 (for N=16) and never wrap.
REQ-022 SHALL use a 3-stage pipeline: S1 latches X and reads the table, S2 forms the product, S3 forms the add and saturation into the o_Y register; latency is 3 cycles from accept to o_valid with no stall.
REQ-023 SHALL sustain one vector per cycle when i_ready=1, with no bubbles.
REQ-024 SHALL freeze all pipeline stages when o_valid && !i_ready; o_Y SHALL stay stable while o_valid && !i_ready.
REQ-025 SHALL drive o_ready = (state==RUN) && !(o_valid && !i_ready); o_ready SHALL NOT depend on i_valid.
REQ-026 SHALL implement FSM states RUN, DRAIN and LOAD.
REQ-027 SHALL, in RUN with i_load_req=1, go to DRAIN next cycle; an input accepted in that same cycle SHALL still be processed.
REQ-028 SHALL, in DRAIN, hold o_ready=0 and go to LOAD on the cycle after the pipeline is empty and the last output has transferred.
REQ-029 SHALL, in LOAD, drive o_load_ack=1; when i_coef_we=1 it SHALL write table[i_coef_addr] = i_coef_data; when i_load_req=0 it SHALL return to RUN next cycle.
REQ-030 SHALL ignore i_coef_we outside LOAD.
REQ-031 SHALL treat a write and the exit from LOAD in the same cycle as a performed write.
REQ-032 SHALL make the table read-only in RUN, so every vector uses one consistent coefficient set.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, set state=RUN, o_valid=0, o_Y=0, o_load_ack=0 and all stage-valid bits to 0; in-flight vectors SHALL be discarded.
REQ-034 SHALL leave table contents unchanged by rst.
REQ-035 SHALL drive o_ready=1 in the first cycle after reset is released.
REQ-036 SHALL give rst priority over all handshakes and writes, including in DRAIN and LOAD.

Verification
REQ-037 Basic PWL: load seg 8 with a=0x0040, b=0x0080; drive all lanes X=0x0100 -> o_Y lanes=0x00C0, o_valid 3 cycles after accept.
REQ-038 Saturation: seg 8 with a=0x7FFF, b=0x7FFF, X=0x0100 -> 0x7FFF; seg 7 with a=0x0000, b=0x8000, X=0xFF00 -> 0x8000.
REQ-039 Backpressure: stream 10 vectors with i_ready toggling randomly -> outputs are in order, none dropped or duplicated, and o_Y is stable while stalled.
REQ-040 Load mid-stream: assert i_load_req with 3 vectors in flight -> all 3 complete with the old coefficients, o_load_ack rises only after drain, and later vectors use the new coefficients.
REQ-041 Reset mid-operation: assert rst in DRAIN with 2 vectors in flight -> o_valid=0 next cycle, no stale output emitted, table retained.
REQ-042 Writes outside LOAD: pulse i_coef_we in RUN -> table unchanged, and outputs match the prior coefficients.
